// File: rtl/raster_frame_reader.sv
// raster_frame_reader
// Measurement sink for the triangle raster stream. Pixels arrive one bit per
// cycle in scan order: rows from MAX_LINHAS down to 0, columns 0 up to
// MAX_COLUNAS within each row. For every complete frame the block reports the
// number of inside pixels and their bounding box on a valid/ready result port.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   pix_valid  pixel present on pix_in
//   pix_ready  block accepts a pixel (transfer on pix_valid & pix_ready)
//   pix_in     1 = pixel inside the triangle, 0 = outside
//   pix_first  marks the first pixel of a frame (forces position to x=0, y=MAX_LINHAS)
//   res_valid  frame result available
//   res_ready  result consumed (transfer on res_valid & res_ready)
//   res_count  number of inside pixels in the frame
//   res_xmin / res_xmax / res_ymin / res_ymax  inside-pixel bounding box
//   res_empty  frame had no inside pixel (bounding box then reads 0)
//   sync_err   one-cycle pulse when pix_first arrives away from the frame start
module raster_frame_reader #(
    parameter int MAX_LINHAS  = 50,
    parameter int MAX_COLUNAS = 75,
    parameter int CW          = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          pix_in,
    input  logic          pix_first,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_count,
    output logic [9:0]    res_xmin,
    output logic [9:0]    res_xmax,
    output logic [9:0]    res_ymin,
    output logic [9:0]    res_ymax,
    output logic          res_empty,
    output logic          sync_err
);

    localparam logic [9:0]    LAST_X = 10'(MAX_COLUNAS);
    localparam logic [9:0]    TOP_Y  = 10'(MAX_LINHAS);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [9:0]    x_r, x_s, y_r, y_s;
    logic [CW-1:0] count_r, count_s;
    logic [9:0]    xmin_r, xmin_s, xmax_r, xmax_s;
    logic [9:0]    ymin_r, ymin_s, ymax_r, ymax_s;
    logic          have_px_r, have_px_s;
    logic          pix_ready_r, pix_ready_s;
    logic          res_valid_r, res_valid_s;
    logic          res_empty_r, res_empty_s;
    logic          sync_err_r, sync_err_s;

    // Effective position and accumulator base for the pixel being taken; a
    // pix_first pixel sees the frame start and cleared accumulators.
    logic [9:0]    eff_x_s, eff_y_s;
    logic [CW-1:0] base_count_s;
    logic [9:0]    base_xmin_s, base_xmax_s, base_ymin_s, base_ymax_s;
    logic          base_have_s;
    logic          take_s;

    assign take_s = pix_valid & pix_ready_r;

    // Next-state, accumulation and position advance
    always_comb begin
        state_s      = state_r;
        x_s          = x_r;
        y_s          = y_r;
        count_s      = count_r;
        xmin_s       = xmin_r;
        xmax_s       = xmax_r;
        ymin_s       = ymin_r;
        ymax_s       = ymax_r;
        have_px_s    = have_px_r;
        sync_err_s   = 1'b0;
        eff_x_s      = x_r;
        eff_y_s      = y_r;
        base_count_s = count_r;
        base_xmin_s  = xmin_r;
        base_xmax_s  = xmax_r;
        base_ymin_s  = ymin_r;
        base_ymax_s  = ymax_r;
        base_have_s  = have_px_r;

        case (state_r)
            ST_ACCUM: begin
                if (take_s) begin
                    if (pix_first) begin
                        eff_x_s      = 10'd0;
                        eff_y_s      = TOP_Y;
                        base_count_s = ZERO_C;
                        base_xmin_s  = 10'd0;
                        base_xmax_s  = 10'd0;
                        base_ymin_s  = 10'd0;
                        base_ymax_s  = 10'd0;
                        base_have_s  = 1'b0;
                        // Resync only when the counters disagree with the marker
                        sync_err_s   = (x_r != 10'd0) || (y_r != TOP_Y);
                    end else begin
                        eff_x_s = x_r;
                        eff_y_s = y_r;
                    end

                    if (pix_in) begin
                        count_s   = base_count_s + ONE_C;
                        have_px_s = 1'b1;
                        if (base_have_s) begin
                            xmin_s = (eff_x_s < base_xmin_s) ? eff_x_s : base_xmin_s;
                            xmax_s = (eff_x_s > base_xmax_s) ? eff_x_s : base_xmax_s;
                            ymin_s = (eff_y_s < base_ymin_s) ? eff_y_s : base_ymin_s;
                            ymax_s = (eff_y_s > base_ymax_s) ? eff_y_s : base_ymax_s;
                        end else begin
                            xmin_s = eff_x_s;
                            xmax_s = eff_x_s;
                            ymin_s = eff_y_s;
                            ymax_s = eff_y_s;
                        end
                    end else begin
                        count_s   = base_count_s;
                        xmin_s    = base_xmin_s;
                        xmax_s    = base_xmax_s;
                        ymin_s    = base_ymin_s;
                        ymax_s    = base_ymax_s;
                        have_px_s = base_have_s;
                    end

                    if (eff_x_s == LAST_X) begin
                        x_s = 10'd0;
                        if (eff_y_s == 10'd0) begin
                            // Last pixel of the frame is included above
                            y_s     = eff_y_s;
                            state_s = ST_RESULT;
                        end else begin
                            y_s = eff_y_s - 10'd1;
                        end
                    end else begin
                        x_s = eff_x_s + 10'd1;
                        y_s = eff_y_s;
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_s   = ST_ACCUM;
                    x_s       = 10'd0;
                    y_s       = TOP_Y;
                    count_s   = ZERO_C;
                    xmin_s    = 10'd0;
                    xmax_s    = 10'd0;
                    ymin_s    = 10'd0;
                    ymax_s    = 10'd0;
                    have_px_s = 1'b0;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            default: begin
                state_s   = ST_ACCUM;
                x_s       = 10'd0;
                y_s       = TOP_Y;
                count_s   = ZERO_C;
                xmin_s    = 10'd0;
                xmax_s    = 10'd0;
                ymin_s    = 10'd0;
                ymax_s    = 10'd0;
                have_px_s = 1'b0;
            end
        endcase

        pix_ready_s = (state_s == ST_ACCUM);
        res_valid_s = (state_s == ST_RESULT);
        res_empty_s = res_valid_s && (count_s == ZERO_C);
    end

    // State, accumulator and registered output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACCUM;
            x_r         <= 10'd0;
            y_r         <= TOP_Y;
            count_r     <= ZERO_C;
            xmin_r      <= 10'd0;
            xmax_r      <= 10'd0;
            ymin_r      <= 10'd0;
            ymax_r      <= 10'd0;
            have_px_r   <= 1'b0;
            pix_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_empty_r <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            count_r     <= count_s;
            xmin_r      <= xmin_s;
            xmax_r      <= xmax_s;
            ymin_r      <= ymin_s;
            ymax_r      <= ymax_s;
            have_px_r   <= have_px_s;
            pix_ready_r <= pix_ready_s;
            res_valid_r <= res_valid_s;
            res_empty_r <= res_empty_s;
            sync_err_r  <= sync_err_s;
        end
    end

    assign pix_ready = pix_ready_r;
    assign res_valid = res_valid_r;
    assign res_count = count_r;
    assign res_xmin  = xmin_r;
    assign res_xmax  = xmax_r;
    assign res_ymin  = ymin_r;
    assign res_ymax  = ymax_r;
    assign res_empty = res_empty_r;
    assign sync_err  = sync_err_r;

endmodule

// File: doc/raster_frame_reader.md
Name: raster_frame_reader

Overview:
- Consumer end of the triangle raster stream: accepts one inside/outside bit per pixel in scan order over the fixed character grid.
- Scan order is row y = MAX_LINHAS down to 0; within each row, column x = 0 up to MAX_COLUNAS.
- Per frame, reports inside-pixel count and bounding box through a valid/ready result port.
- Sits downstream of the rasterizer as its checker/measurement sink.

Parameters:
- MAX_LINHAS, 50, highest row index; grid has MAX_LINHAS+1 rows.
- MAX_COLUNAS, 75, highest column index; grid has MAX_COLUNAS+1 columns.
- CW, 13, width of the pixel counter; must hold (MAX_LINHAS+1)*(MAX_COLUNAS+1) = 3876.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  block accepts pixel; transfer when pix_valid & pix_ready.
- pix_in  in  1  1 = pixel inside the triangle (printed ' '), 0 = outside (printed '-').
- pix_first  in  1  marks first pixel of a frame (x=0, y=MAX_LINHAS).
- res_valid  out  1  frame result available.
- res_ready  in  1  result consumed; transfer when res_valid & res_ready.
- res_count  out  CW  number of inside pixels in the frame.
- res_xmin, res_xmax  out  10  inside-pixel column range.
- res_ymin, res_ymax  out  10  inside-pixel row range.
- res_empty  out  1  1 when res_count = 0; all bbox outputs are then 0.
- sync_err  out  1  one-cycle pulse on a frame resync.

Behaviour:
- Reset (async, rst_n=0): state ACCUM, x=0, y=MAX_LINHAS, count=0, bbox cleared, have_px=0.
  - Outputs during reset: pix_ready=0, res_valid=0, all res_* = 0, res_empty=0, sync_err=0.
  - After release: pix_ready=1 from the first clock edge.
- State ACCUM:
  - pix_ready=1; one pixel per cycle.
  - On each accepted pixel with pix_in=1:
    - count += 1.
    - If have_px=0: load xmin=xmax=x and ymin=ymax=y; set have_px=1.
    - Otherwise: xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y).
  - Position advance: x+1. At x=MAX_COLUNAS, wrap x to 0 and decrement y.
  - Last pixel (x=MAX_COLUNAS, y=0): its bit is included, then go to RESULT.
- State RESULT:
  - pix_ready=0, res_valid=1.
  - res_* registers show the final accumulators and stay stable until the handshake.
  - On res_ready=1: clear accumulators and have_px, set x=0, y=MAX_LINHAS, return to ACCUM.
  - pix_ready returns to 1 on the next cycle.
- Latency and throughput:
  - res_valid rises the cycle after the last pixel is accepted.
  - Minimum inter-frame gap is 1 cycle when res_ready is held at 1.
- pix_first handling, on an accepted pixel with pix_first=1:
  - That pixel is forced to position (0, MAX_LINHAS).
  - Accumulators are cleared before that pixel is included.
  - If the position counter was not already at (0, MAX_LINHAS), sync_err pulses for exactly 1 cycle and the partial frame is discarded.
  - pix_first=1 at the expected position is legal and silent.
- pix_first=0 on the first pixel is legal: frame position comes from the counters alone.
- pix_valid=0 cycles in ACCUM do not advance position.
- pix_in and pix_first are ignored when no transfer occurs.
- Arithmetic: all unsigned, no wrap possible (count ≤ 3876 < 2^13); comparisons are unsigned on 10-bit coordinates.
- No result is ever dropped: RESULT blocks further input indefinitely.
- Reset mid-frame or mid-RESULT: immediate return to the reset values above; the partial frame is lost; no sync_err.

Test Plan:
- Rasterized triangle A(0,0) B(10,0) C(0,30), boundary counted as inside (3x+y ≤ 30), res_ready=1 -> res_count=176, xmin=0, xmax=10, ymin=0, ymax=30, res_empty=0; res_valid exactly 1 cycle after pixel 3876.
- All-zero frame -> res_count=0, res_empty=1, bbox=0; all-one frame -> res_count=3876, x 0..75, y 0..50.
- Only the last pixel (x=75, y=0) inside -> count=1, xmin=xmax=75, ymin=ymax=0 (last-pixel inclusion check).
- Backpressure: res_ready held 0 for 5 cycles after res_valid, pix_valid held 1 -> pix_ready=0 throughout, res_* stable, no pixel accepted; the next frame starts the cycle after the handshake.
- pix_first asserted on pixel 100 of a frame, followed by a full triangle frame -> one sync_err pulse; result equals the triangle case (176); the first 99 pixels are not counted.
- rst_n pulsed low after 500 pixels, then a full all-one frame -> outputs zero during reset; next result count=3876; no sync_err.
